pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'd0, is the word index loaded into pc on reset.
REQ-002 Parameter MEM_WORDS, default 1024, is the instruction memory depth in words (informational; pc is not clamped).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  output  32  word index driven to the instruction fetch stage, which returns its word combinationally.
REQ-006 instr  input  32  instruction word for the current pc, from the fetch stage.
REQ-007 isdone  input  1  fetch-stage flag: the word at pc is undefined, so the program has ended.
REQ-008 redirect  input  1  branch/jump taken from execute; one-cycle pulse.
REQ-009 redirect_pc  input  32  target word index, valid while redirect=1.
REQ-010 out_valid  output  1  out_instr/out_pc hold an instruction for decode.
REQ-011 out_ready  input  1  decode accepts the held instruction this cycle.
REQ-012 out_instr  output  32  registered instruction to decode.
REQ-013 out_pc  output  32  word index of out_instr.
REQ-014 halted  output  1  sequencer is in HALT.
REQ-015 instr_count  output  32  number of completed out_valid&out_ready handshakes since reset.

Function
REQ-016 The states are RUN, DRAIN and HALT.
REQ-017 "Slot free" = !out_valid | out_ready.
REQ-018 Priority each cycle: rst > redirect > normal sequencing.
REQ-019 In RUN or DRAIN with redirect=1: pc<=redirect_pc; out_valid<=0 (flush, even if out_ready=1); next state RUN; instr_count still increments if a handshake completes that cycle.
REQ-020 In RUN, slot free, isdone=0, no redirect: out_instr<=instr; out_pc<=pc; out_valid<=1; pc<=pc+1. One instruction issues per cycle at full throughput, with latency of one cycle from pc to out_valid.
REQ-021 In RUN, slot free, isdone=1, no redirect: nothing is loaded; pc holds; out_valid<=0 if out_ready, else it holds; next state DRAIN.
REQ-022 In RUN, slot not free (out_valid=1, out_ready=0): pc, out_instr, out_pc and out_valid hold (stall); isdone is ignored that cycle.
REQ-023 In DRAIN: pc holds; when !out_valid, or out_valid&out_ready, the next state is HALT and out_valid<=0.
REQ-024 In HALT: pc holds; out_valid=0; halted=1; redirect, isdone and out_ready are ignored; only rst leaves HALT.
REQ-025 pc+1 wraps modulo 2^32 (32'hFFFFFFFF -> 0).
REQ-026 A redirect_pc >= MEM_WORDS is loaded unchanged; the resulting isdone path ends the program normally.
REQ-027 instr_count increments by 1 on each out_valid&out_ready cycle and wraps modulo 2^32.
REQ-028 out_instr and out_pc change only when a new instruction loads; they are don't-care while out_valid=0.

Reset
REQ-029 When rst=1 at a clock edge: pc<=RESET_PC; out_valid<=0; out_instr<=0; out_pc<=0; instr_count<=0; state<=RUN; halted<=0.
REQ-030 Reset mid-operation (including in DRAIN or HALT, or during a stall) discards the held instruction with no handshake counted.
REQ-031 The first fetch issues on the first edge after rst deasserts.

Structure
REQ-032 A shared package holds the state enumeration (RUN, DRAIN, HALT), the default RESET_PC and the 32-bit word-width constant.
REQ-033 One sub-module is natural: if_id_reg, the valid/ready output holding register with flush and load inputs; the pc register, state machine and counter stay in pc_sequencer.

Verification
REQ-034 Reset, then a 4-word program with out_ready=1 -> out_pc=0,1,2,3 on consecutive cycles; isdone at pc=4 -> DRAIN then HALT; instr_count=4; halted=1.
REQ-035 out_ready=0 for 3 cycles while out_pc=2 -> pc stays 3; out_instr/out_pc stable; no count increment; the sequence resumes with out_pc=3.
REQ-036 redirect=1, redirect_pc=10 while out_valid=1, out_pc=5 -> next cycle out_valid=0, pc=10; the cycle after that, out_pc=10.
REQ-037 isdone at pc=6 while out_pc=5 is stalled, then redirect to 2 in DRAIN -> state RUN, out_valid=0, pc=2; the program continues.
REQ-038 rst asserted in HALT and mid-stall -> next cycle pc=RESET_PC, out_valid=0, instr_count=0, halted=0.
REQ-039 redirect_pc=32'hFFFFFFFF with valid instr -> out_pc=32'hFFFFFFFF; the next pc is 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, redirect, decode-handshake and status signals of the sequencer.
// master = sequencer side, slave = surrounding pipeline.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr;
  logic              isdone;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic              halted;
  logic [WORD_W-1:0] instr_count;

  modport master (
    output pc,
    input  instr,
    input  isdone,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted,
    output instr_count
  );

  modport slave (
    input  pc,
    output instr,
    output isdone,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  instr_count
  );

endinterface

// File: rtl/pc_sequencer_if_id_reg.sv
// Valid/ready holding register between fetch and decode.
// Priority: rst > flush > load > consume.
module if_id_reg
  import pc_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              ready,
  input  logic [WORD_W-1:0] d_instr,
  input  logic [WORD_W-1:0] d_pc,
  output logic              valid,
  output logic [WORD_W-1:0] q_instr,
  output logic [WORD_W-1:0] q_pc
);

  // Hold the issued instruction until decode takes it; a flush drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one instruction per cycle to decode,
// follows redirects, and drains then halts once fetch reports end of program.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | fetching and issuing sequentially from pc
// ST_DRAIN | end of program seen; waiting for the last held word to leave
// ST_HALT  | stopped; only reset restarts the sequencer
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int                MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    bus
);

  // pc is deliberately not clamped to the memory depth; the depth only
  // needs to be sane.
  if (MEM_WORDS < 1) begin : g_depth_check
    $error("pc_sequencer: MEM_WORDS must be at least 1");
  end

  state_t            state;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] count_q;
  logic              halted_q;

  logic              held_valid;
  logic [WORD_W-1:0] held_instr;
  logic [WORD_W-1:0] held_pc;

  logic              slot_free;
  logic              flush;
  logic              load;
  logic              handshake;

  assign slot_free = !held_valid || bus.out_ready;
  assign handshake = held_valid && bus.out_ready;
  // Redirect is ignored once halted; held_valid is already low there.
  assign flush     = bus.redirect && (state != ST_HALT);
  assign load      = (state == ST_RUN) && !bus.redirect && slot_free && !bus.isdone;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (load),
    .ready   (bus.out_ready),
    .d_instr (bus.instr),
    .d_pc    (pc_q),
    .valid   (held_valid),
    .q_instr (held_instr),
    .q_pc    (held_pc)
  );

  // State machine, pc register and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (handshake) begin
        count_q <= count_q + 32'd1;
      end
      case (state)
        ST_RUN: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end else if (slot_free) begin
            if (bus.isdone) begin
              state <= ST_DRAIN;
            end else begin
              pc_q <= pc_q + 32'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.redirect) begin
            pc_q  <= bus.redirect_pc;
            state <= ST_RUN;
          end else if (slot_free) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.out_valid   = held_valid;
  assign bus.out_instr   = held_instr;
  assign bus.out_pc      = held_pc;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(32'd0), .MEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Fetch stage: a program of prog_len words; optionally the top word of
  // the address space also holds a valid instruction.
  logic [31:0] prog_len = 32'd4;
  logic        hi_ok    = 1'b0;

  function automatic logic [31:0] fetch_word(input logic [31:0] p);
    return (p * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic fetch_done(input logic [31:0] p);
    return (p >= prog_len) && !(hi_ok && (p == 32'hFFFF_FFFF));
  endfunction

  assign bus.instr  = fetch_word(bus.pc);
  assign bus.isdone = fetch_done(bus.pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = draining, 2 = halted.
  int          m_mode;
  logic        m_live = 1'b0;
  logic [31:0] m_pc, m_instr, m_opc, m_count;
  logic        m_valid;

  always @(posedge clk) begin
    logic fire;
    fire = m_valid && bus.out_ready;
    if (rst) begin
      m_live  = 1'b1;
      m_mode  = 0;
      m_pc    = 32'd0;
      m_valid = 1'b0;
      m_instr = 32'd0;
      m_opc   = 32'd0;
      m_count = 32'd0;
    end else if (m_live && m_mode != 2) begin
      if (fire) m_count = m_count + 1;
      if (bus.redirect) begin
        m_pc    = bus.redirect_pc;
        m_valid = 1'b0;
        m_mode  = 0;
      end else if (!m_valid || bus.out_ready) begin
        if (m_mode == 0 && !fetch_done(m_pc)) begin
          m_instr = fetch_word(m_pc);
          m_opc   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 1;
        end else begin
          m_valid = 1'b0;
          m_mode  = m_mode + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("pc", bus.pc, m_pc);
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("halted", {31'd0, bus.halted}, (m_mode == 2) ? 32'd1 : 32'd0);
      chk("instr_count", bus.instr_count, m_count);
      if (m_valid) begin
        chk("out_pc", bus.out_pc, m_opc);
        chk("out_instr", bus.out_instr, m_instr);
      end
    end
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] len, input logic hi);
    rst = 1'b1;
    prog_len = len;
    hi_ok = hi;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready = 1'b1;
    nclk();
    nclk();
    rst = 1'b0;
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.out_ready = 1'b1;

    // Basic 4-word program, then drain and halt.
    do_reset(32'd4, 1'b0);
    chk("reset_pc", bus.pc, 32'd0);
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_count", bus.instr_count, 32'd0);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      nclk();
      chk("seq_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("seq_out_pc", bus.out_pc, i);
    end
    nclk();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_halted", {31'd0, bus.halted}, 32'd0);
    nclk();
    chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_count", bus.instr_count, 32'd4);
    chk("halt_pc", bus.pc, 32'd4);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd1;
    nclk();
    bus.redirect = 1'b0;
    chk("halt_ignores_redirect", bus.pc, 32'd4);
    // Reset out of HALT.
    rst = 1'b1;
    nclk();
    rst = 1'b0;
    chk("rst_halt_pc", bus.pc, 32'd0);
    chk("rst_halt_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_halt_count", bus.instr_count, 32'd0);

    // Stall for three cycles while out_pc = 2.
    do_reset(32'd100, 1'b0);
    nclk(); nclk(); nclk();
    chk("pre_stall_out_pc", bus.out_pc, 32'd2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      chk("stall_pc", bus.pc, 32'd3);
      chk("stall_out_pc", bus.out_pc, 32'd2);
      chk("stall_out_instr", bus.out_instr, fetch_word(32'd2));
      chk("stall_count", bus.instr_count, 32'd2);
    end
    bus.out_ready = 1'b1;
    nclk();
    chk("resume_out_pc", bus.out_pc, 32'd3);
    chk("resume_count", bus.instr_count, 32'd3);
    nclk(); nclk();
    chk("pre_redirect_out_pc", bus.out_pc, 32'd5);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd10;
    nclk();
    bus.redirect = 1'b0;
    chk("redirect_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redirect_pc", bus.pc, 32'd10);
    nclk();
    chk("redirect_out_pc", bus.out_pc, 32'd10);
    chk("redirect_valid", {31'd0, bus.out_valid}, 32'd1);
    // Reset in the middle of a stall.
    bus.out_ready = 1'b0;
    nclk();
    rst = 1'b1;
    nclk();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_stall_pc", bus.pc, 32'd0);
    chk("rst_stall_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_stall_count", bus.instr_count, 32'd0);

    // End of program seen while out_pc = 5 is stalled, then redirect in DRAIN.
    do_reset(32'd6, 1'b0);
    for (int i = 0; i < 6; i++) nclk();
    chk("done_out_pc", bus.out_pc, 32'd5);
    chk("done_pc", bus.pc, 32'd6);
    bus.out_ready = 1'b0;
    nclk();
    chk("done_stall_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    nclk();
    chk("drain_entry_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_entry_halted", {31'd0, bus.halted}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd2;
    nclk();
    bus.redirect = 1'b0;
    chk("drain_redirect_pc", bus.pc, 32'd2);
    chk("drain_redirect_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_redirect_halted", {31'd0, bus.halted}, 32'd0);
    nclk();
    chk("drain_continue_out_pc", bus.out_pc, 32'd2);
    chk("drain_continue_count", bus.instr_count, 32'd6);

    // pc wrap at the top of the address space.
    do_reset(32'd100, 1'b1);
    nclk();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    nclk();
    bus.redirect = 1'b0;
    chk("wrap_redirect_pc", bus.pc, 32'hFFFF_FFFF);
    nclk();
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFF);
    chk("wrap_next_pc", bus.pc, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if (($urandom_range(0, 199) == 0) || (bus.halted && $urandom_range(0, 7) == 0)) begin
        rst = 1'b1;
        prog_len = $urandom_range(1, 40);
        hi_ok = $urandom_range(0, 1);
      end else begin
        rst = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) bus.redirect_pc = 32'hFFFF_FFFF;
      else bus.redirect_pc = $urandom_range(0, prog_len + 3);
      nclk();
    end
    rst = 1'b0;
    bus.redirect = 1'b0;
    nclk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
